// File: rtl/rx_lane_sync_if.sv
// rtl/rx_lane_sync_if.sv - byte stream bundle between deserializer, lane sync and consumer
interface rx_lane_sync_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic [7:0] data_out;
    logic       valid_out;

    modport master (
        output data_in,
        output valid_in,
        input  data_out,
        input  valid_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output data_out,
        output valid_out
    );
endinterface

// File: rtl/rx_lane_sync.sv
// rtl/rx_lane_sync.sv - comma-based lane synchronizer; RX_LANE_SYNC_ERRCNT_EN adds a saturating loss_events counter
module rx_lane_sync #(
    parameter logic [7:0] COM_SYMBOL = 8'hBC,
    parameter int         LOCK_CNT   = 4,
    parameter int         LOSS_CNT   = 3
) (
    input  logic              clk_f,
    input  logic              reset,
    input  logic              en,
    rx_lane_sync_if.slave     bus,
    output logic              synced,
    output logic              sync_lost,
    output logic [2:0]        state
`ifdef RX_LANE_SYNC_ERRCNT_EN
    ,
    output logic [7:0]        loss_events
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        CHECK  = 3'd2,
        SYNCED = 3'd3,
        LOST   = 3'd4
    } state_e;

    localparam logic [3:0] LOCK_C = 4'(LOCK_CNT);
    localparam logic [3:0] LOSS_C = 4'(LOSS_CNT);

    state_e     state_q, state_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [3:0] err_cnt_q, err_cnt_d;
    logic [7:0] data_out_q, data_out_d;
    logic       valid_out_q, valid_out_d;
    logic       synced_q, synced_d;
    logic       sync_lost_q, sync_lost_d;

    logic       is_com;
    logic [3:0] com_inc;
    logic [3:0] err_inc;

    assign is_com  = bus.valid_in && (bus.data_in == COM_SYMBOL);
    assign com_inc = com_cnt_q + 4'd1;
    assign err_inc = err_cnt_q + 4'd1;

    always_ff @(posedge clk_f) begin
        if (reset) begin
            state_q   <= IDLE;
            com_cnt_q <= 4'd0;
            err_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            com_cnt_q <= com_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        com_cnt_d = 4'd0;
        err_cnt_d = 4'd0;
        if (!en) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = SEARCH;
                SEARCH: begin
                    if (is_com) begin
                        com_cnt_d = 4'd1;
                        state_d   = (LOCK_C == 4'd1) ? SYNCED : CHECK;
                    end
                end
                CHECK: begin
                    if (is_com) begin
                        com_cnt_d = com_inc;
                        if (com_inc == LOCK_C) state_d = SYNCED;
                    end else begin
                        state_d = SEARCH;
                    end
                end
                SYNCED: begin
                    com_cnt_d = com_cnt_q;
                    // Terminal compare fires before the counter can wrap.
                    if (!bus.valid_in) begin
                        err_cnt_d = err_inc;
                        if (err_inc == LOSS_C) state_d = LOST;
                    end
                end
                LOST:    state_d = SEARCH;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        synced_d    = (state_d == SYNCED);
        sync_lost_d = (state_d == LOST);
        if (en && state_q == SYNCED && bus.valid_in && !is_com) begin
            data_out_d  = bus.data_in;
            valid_out_d = 1'b1;
        end
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            data_out_q  <= 8'd0;
            valid_out_q <= 1'b0;
            synced_q    <= 1'b0;
            sync_lost_q <= 1'b0;
        end else begin
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            synced_q    <= synced_d;
            sync_lost_q <= sync_lost_d;
        end
    end

`ifdef RX_LANE_SYNC_ERRCNT_EN
    logic [7:0] loss_events_q;

    always_ff @(posedge clk_f) begin
        if (reset) begin
            loss_events_q <= 8'd0;
        end else if (state_d == LOST && state_q != LOST && loss_events_q != 8'hFF) begin
            loss_events_q <= loss_events_q + 8'd1;
        end
    end

    assign loss_events = loss_events_q;
`endif

    assign bus.data_out  = data_out_q;
    assign bus.valid_out = valid_out_q;
    assign synced        = synced_q;
    assign sync_lost     = sync_lost_q;
    assign state         = state_q;

endmodule

// File: tb/tb_rx_lane_sync.sv
// tb/tb_rx_lane_sync.sv - scoreboard bench for rx_lane_sync with directed lock/loss/disable/reset vectors
module tb_rx_lane_sync;
    logic       clk_f;
    logic       reset;
    logic       en;
    logic       synced;
    logic       sync_lost;
    logic [2:0] state;
`ifdef RX_LANE_SYNC_ERRCNT_EN
    logic [7:0] loss_events;
`endif

    rx_lane_sync_if bus ();

    rx_lane_sync dut (
        .clk_f       (clk_f),
        .reset       (reset),
        .en          (en),
        .bus         (bus),
        .synced      (synced),
        .sync_lost   (sync_lost),
        .state       (state)
`ifdef RX_LANE_SYNC_ERRCNT_EN
        ,
        .loss_events (loss_events)
`endif
    );

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_q[$];

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic v, input logic [7:0] d);
        en           = e;
        bus.valid_in = v;
        bus.data_in  = d;
        @(posedge clk_f);
        #1;
    endtask

    task automatic lock4();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'hBC);
    endtask

    always @(negedge clk_f) begin
        if (!reset && bus.valid_out === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got %0h expected no output at %0t", bus.data_out, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.data_out !== e) begin
                    errors++;
                    $display("FAIL data_out: got %0h expected %0h at %0t", bus.data_out, e, $time);
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        en           = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        step(1'b0, 1'b0, 8'h00);
        chk("rst_state", {5'd0, state}, 8'd0);
        chk("rst_synced", {7'd0, synced}, 8'd0);
        chk("rst_lost", {7'd0, sync_lost}, 8'd0);
        chk("rst_vout", {7'd0, bus.valid_out}, 8'd0);
        chk("rst_dout", bus.data_out, 8'd0);

        // Lock: 4 commas then payload
        reset = 1'b0;
        step(1'b1, 1'b0, 8'h00);
        chk("idle_to_search", {5'd0, state}, 8'd1);
        step(1'b1, 1'b1, 8'hBC);
        step(1'b1, 1'b1, 8'hBC);
        step(1'b1, 1'b1, 8'hBC);
        chk("check_state", {5'd0, state}, 8'd2);
        chk("check_synced", {7'd0, synced}, 8'd0);
        step(1'b1, 1'b1, 8'hBC);
        chk("lock_state", {5'd0, state}, 8'd3);
        chk("lock_synced", {7'd0, synced}, 8'd1);
        exp_q.push_back(8'h5A);
        step(1'b1, 1'b1, 8'h5A);
        chk("fwd_vout", {7'd0, bus.valid_out}, 8'd1);

        // Error clear
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("err2_state", {5'd0, state}, 8'd3);
        exp_q.push_back(8'h22);
        step(1'b1, 1'b1, 8'h22);
        step(1'b1, 1'b0, 8'h00);
        chk("errclr_state", {5'd0, state}, 8'd3);
        chk("errclr_lost", {7'd0, sync_lost}, 8'd0);
        step(1'b1, 1'b1, 8'hBC);
        chk("com_vout", {7'd0, bus.valid_out}, 8'd0);
        chk("com_hold", bus.data_out, 8'h22);

        // Loss
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("loss2_state", {5'd0, state}, 8'd3);
        step(1'b1, 1'b0, 8'h00);
        chk("lost_state", {5'd0, state}, 8'd4);
        chk("lost_pulse", {7'd0, sync_lost}, 8'd1);
        chk("lost_synced", {7'd0, synced}, 8'd0);
`ifdef RX_LANE_SYNC_ERRCNT_EN
        chk("loss_events1", loss_events, 8'd1);
`endif
        step(1'b1, 1'b0, 8'h00);
        chk("after_lost_state", {5'd0, state}, 8'd1);
        chk("after_lost_pulse", {7'd0, sync_lost}, 8'd0);

        // Disable while SYNCED
        lock4();
        chk("relock_state", {5'd0, state}, 8'd3);
        exp_q.push_back(8'h33);
        step(1'b1, 1'b1, 8'h33);
        step(1'b0, 1'b1, 8'h44);
        chk("dis_state", {5'd0, state}, 8'd0);
        chk("dis_vout", {7'd0, bus.valid_out}, 8'd0);
        chk("dis_hold", bus.data_out, 8'h33);

        // Reset mid-CHECK
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hBC);
        step(1'b1, 1'b1, 8'hBC);
        chk("midcheck_state", {5'd0, state}, 8'd2);
        reset = 1'b1;
        step(1'b1, 1'b1, 8'hBC);
        chk("rstchk_state", {5'd0, state}, 8'd0);
        chk("rstchk_dout", bus.data_out, 8'd0);
        chk("rstchk_vout", {7'd0, bus.valid_out}, 8'd0);
        chk("rstchk_synced", {7'd0, synced}, 8'd0);
        chk("rstchk_lost", {7'd0, sync_lost}, 8'd0);

        // Broken lock
        reset = 1'b0;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, 8'hBC);
        step(1'b1, 1'b1, 8'hBC);
        step(1'b1, 1'b1, 8'hBC);
        step(1'b1, 1'b1, 8'h11);
        chk("broken_state", {5'd0, state}, 8'd1);
        chk("broken_synced", {7'd0, synced}, 8'd0);
        step(1'b1, 1'b1, 8'hBC);
        chk("broken_recheck", {5'd0, state}, 8'd2);
        chk("broken_synced2", {7'd0, synced}, 8'd0);

        // Reset during LOST
        step(1'b1, 1'b1, 8'hBC);
        step(1'b1, 1'b1, 8'hBC);
        step(1'b1, 1'b1, 8'hBC);
        chk("lock2_state", {5'd0, state}, 8'd3);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        chk("lost2_state", {5'd0, state}, 8'd4);
        reset = 1'b1;
        step(1'b1, 1'b0, 8'h00);
        chk("rstlost_state", {5'd0, state}, 8'd0);
        chk("rstlost_pulse", {7'd0, sync_lost}, 8'd0);
`ifdef RX_LANE_SYNC_ERRCNT_EN
        chk("rstlost_events", loss_events, 8'd0);

        // Saturation
        reset = 1'b0;
        step(1'b1, 1'b0, 8'h00);
        for (int n = 0; n < 300; n++) begin
            lock4();
            step(1'b1, 1'b0, 8'h00);
            step(1'b1, 1'b0, 8'h00);
            step(1'b1, 1'b0, 8'h00);
            step(1'b1, 1'b0, 8'h00);
            if (n == 254) chk("events_255", loss_events, 8'hFF);
        end
        chk("events_sat", loss_events, 8'hFF);
`endif

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
